// File: rtl/decimation_sequencer.sv
// ---------------------------------------------------------------------------
// decimation_sequencer
//
// Purpose
//   Frame sequencer for a decimating accumulator. A sample index (count)
//   runs 1..active_ratio and then wraps back to 1. Each wrap closes one
//   frame. A new downsampling ratio can be requested at any time, but it
//   only takes effect at a frame boundary, so the frame in progress is
//   never cut short or stretched.
//
//   The block also produces these outputs:
//   - a valid-window flag
//   - staggered per-channel readout strobes
//   - a frame counter
//   - an acknowledge pulse and a sticky error flag for ratio requests
//
// Ports
//   clk         : single clock, all state changes on its rising edge
//   reset       : asynchronous, active-high reset
//   enable      : count advances only while high
//   ratio_in    : requested downsampling ratio
//   ratio_load  : single-cycle request to take ratio_in
//   window_len  : valid-window length, used live (not registered)
//   err_clr     : clears ratio_err
//   count       : current sample index within the frame (0 only after reset)
//   equal       : count has reached the active ratio (last sample of frame)
//   valid       : count is inside the valid window
//   dump        : per-channel readout strobes, dump[i] at count == i+1
//   frame_cnt   : completed frames, wraps modulo 2^FRAME_WIDTH
//   ratio_ack   : one-cycle pulse the cycle after a new ratio takes effect
//   ratio_err   : sticky flag, set by a rejected ratio request
// ---------------------------------------------------------------------------
module decimation_sequencer #(
   parameter int ACCUMULATIONS_WIDTH = 16,
   parameter int NUM_CHANNELS        = 4,
   parameter int FRAME_WIDTH         = 16,
   parameter int DEFAULT_RATIO       = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           enable,
   input  logic [ACCUMULATIONS_WIDTH-1:0] ratio_in,
   input  logic                           ratio_load,
   input  logic [ACCUMULATIONS_WIDTH-1:0] window_len,
   input  logic                           err_clr,
   output logic [ACCUMULATIONS_WIDTH-1:0] count,
   output logic                           equal,
   output logic                           valid,
   output logic [NUM_CHANNELS-1:0]        dump,
   output logic [FRAME_WIDTH-1:0]         frame_cnt,
   output logic                           ratio_ack,
   output logic                           ratio_err
);

   // Ratio currently governing the frame, and a one-deep holding slot for
   // a request that is still waiting for the next frame boundary.
   logic [ACCUMULATIONS_WIDTH-1:0] active_ratio;
   logic [ACCUMULATIONS_WIDTH-1:0] pending_ratio;
   logic                           pending;

   // Decoded internal conditions
   logic count_at_ratio;
   logic count_is_zero;
   logic frame_boundary;
   logic frame_complete;
   logic load_ok;
   logic load_bad;
   logic apply_now;

   // Decode the frame position from registered state only. There are two
   // kinds of boundary edge:
   //   - the 0->1 start-up step, which restarts the count but does not
   //     close a frame;
   //   - the ratio->1 wrap, which restarts the count and also closes a
   //     frame.
   // A ratio below NUM_CHANNELS is rejected: a frame that short could not
   // give every channel its own dump slot.
   always_comb begin
      count_at_ratio = (count == active_ratio);
      count_is_zero  = (count == '0);
      frame_boundary = enable && (count_is_zero || count_at_ratio);
      frame_complete = enable && count_at_ratio;
      load_ok        = ratio_load && (ratio_in >= ACCUMULATIONS_WIDTH'(NUM_CHANNELS));
      load_bad       = ratio_load && !load_ok;
      apply_now      = frame_boundary && (pending || load_ok);
   end

   // Sample index. On a boundary edge the count restarts at 1. On every
   // other enabled edge it steps by one. It holds while enable is low.
   // Ratios only change on boundary edges, so count can never run past
   // the ratio that governs its frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (enable) begin
         if (count_is_zero || count_at_ratio) begin
            count <= ACCUMULATIONS_WIDTH'(1);
         end else begin
            count <= count + ACCUMULATIONS_WIDTH'(1);
         end
      end
   end

   // Active ratio update. This happens only on a boundary edge.
   //   - A valid request arriving on that same edge goes straight in,
   //     bypassing the holding slot, so the newest request always wins.
   //   - Otherwise a waiting pending request is applied.
   // Either way the frame that starts on this edge runs under the new
   // ratio.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         active_ratio <= ACCUMULATIONS_WIDTH'(DEFAULT_RATIO);
      end else if (frame_boundary) begin
         if (load_ok) begin
            active_ratio <= ratio_in;
         end else if (pending) begin
            active_ratio <= pending_ratio;
         end
      end
   end

   // Holding slot for a ratio request.
   //   - Applying a request (from the slot or by bypass) empties the slot.
   //   - A valid request on any other edge overwrites the slot (latest
   //     wins). This includes edges with enable low.
   //   - A rejected request never touches the slot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_ratio <= '0;
         pending       <= 1'b0;
      end else if (apply_now) begin
         pending <= 1'b0;
      end else if (load_ok) begin
         pending_ratio <= ratio_in;
         pending       <= 1'b1;
      end
   end

   // Completed-frame counter. It counts only the wrap from the last sample
   // of a frame, never the start-up step out of count 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_cnt <= '0;
      end else if (frame_complete) begin
         frame_cnt <= frame_cnt + FRAME_WIDTH'(1);
      end
   end

   // Acknowledge is a registered copy of the apply condition. It is
   // therefore high for exactly the first cycle of the frame that runs
   // under the newly applied ratio.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ratio_ack <= 1'b0;
      end else begin
         ratio_ack <= apply_now;
      end
   end

   // Sticky rejection flag. Setting takes priority over clearing, so an
   // error raised in the same cycle as err_clr is not lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ratio_err <= 1'b0;
      end else if (load_bad) begin
         ratio_err <= 1'b1;
      end else if (err_clr) begin
         ratio_err <= 1'b0;
      end
   end

   // Status outputs, decoded from registered state. They are forced low
   // while reset is held, so nothing downstream sees a strobe during
   // reset.
   always_comb begin
      equal = !reset && count_at_ratio;
      valid = !reset && !count_is_zero && (count <= window_len);
   end

   // Staggered channel strobes: channel i reads out at sample i+1. The
   // strobes are qualified by enable, so a paused frame never repeats a
   // strobe while the count is held.
   genvar ch;
   generate
      for (ch = 0; ch < NUM_CHANNELS; ch++) begin : g_dump
         assign dump[ch] = !reset && enable &&
                           (count == ACCUMULATIONS_WIDTH'(ch + 1));
      end
   endgenerate

endmodule
